// File: rtl/corelet_ctrl.sv
// corelet_ctrl: per kernel offset, fills L0 with weights, loads them into the mac_array,
// refills L0 with activations, executes them, then drains; repeats for KIJ offsets.
module corelet_ctrl #(
  parameter int ROW     = 8,
  parameter int COL     = 8,
  parameter int N_ACT   = 36,
  parameter int KIJ     = 9,
  parameter int GAP     = ROW + COL,
  parameter int DRAIN   = 16,
  parameter int ADDR_BW = 11
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               l0_full,
  output logic               l0_wr,
  output logic               l0_rd,
  output logic               load,
  output logic               execute,
  output logic [ADDR_BW-1:0] w_addr,
  output logic [ADDR_BW-1:0] a_addr,
  output logic [3:0]         kij_idx,
  output logic               busy,
  output logic               done
);

  localparam int MAX_A   = (COL > N_ACT) ? COL : N_ACT;
  localparam int MAX_B   = (GAP > DRAIN) ? GAP : DRAIN;
  localparam int CNT_MAX = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CW      = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_WFILL, S_WLOAD, S_WGAP, S_AFILL, S_AEXEC, S_DRAIN, S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [3:0]         kij_q, kij_d;
  logic               l0_wr_q, l0_wr_d, l0_rd_q, l0_rd_d;
  logic               load_q, load_d, exec_q, exec_d;
  logic               busy_q, busy_d, done_q, done_d;
  logic [ADDR_BW-1:0] w_addr_q, w_addr_d, a_addr_q, a_addr_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CW'(1);
    kij_d   = kij_q;
    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (start) begin
          state_d = S_WFILL;
          kij_d   = '0;
        end
      end
      // Fill phases count only the words actually written, so stalls stretch the phase.
      S_WFILL: begin
        cnt_d = cnt_q + CW'(l0_wr_q);
        if (l0_wr_q && cnt_q == CW'(COL - 1)) begin
          state_d = S_WLOAD;
          cnt_d   = '0;
        end
      end
      S_WLOAD: if (cnt_q == CW'(COL - 1)) begin
        state_d = S_WGAP;
        cnt_d   = '0;
      end
      S_WGAP: if (cnt_q == CW'(GAP - 1)) begin
        state_d = S_AFILL;
        cnt_d   = '0;
      end
      S_AFILL: begin
        cnt_d = cnt_q + CW'(l0_wr_q);
        if (l0_wr_q && cnt_q == CW'(N_ACT - 1)) begin
          state_d = S_AEXEC;
          cnt_d   = '0;
        end
      end
      S_AEXEC: if (cnt_q == CW'(N_ACT - 1)) begin
        state_d = S_DRAIN;
        cnt_d   = '0;
      end
      S_DRAIN: if (cnt_q == CW'(DRAIN - 1)) begin
        cnt_d = '0;
        if (kij_q == 4'(KIJ - 1)) begin
          state_d = S_DONE;
        end else begin
          state_d = S_WFILL;
          kij_d   = kij_q + 4'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase

    // Outputs are decoded from the state being entered so they are registered with it.
    l0_wr_d  = ((state_d == S_WFILL) || (state_d == S_AFILL)) && !l0_full;
    l0_rd_d  = (state_d == S_WLOAD) || (state_d == S_AEXEC);
    load_d   = (state_d == S_WLOAD);
    exec_d   = (state_d == S_AEXEC);
    busy_d   = (state_d != S_IDLE) && (state_d != S_DONE);
    done_d   = (state_d == S_DONE);
    w_addr_d = (state_d == S_WFILL) ?
               ADDR_BW'(kij_d) * ADDR_BW'(COL) + ADDR_BW'(cnt_d) : w_addr_q;
    a_addr_d = (state_d == S_AFILL) ? ADDR_BW'(cnt_d) : a_addr_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      kij_q    <= '0;
      l0_wr_q  <= 1'b0;
      l0_rd_q  <= 1'b0;
      load_q   <= 1'b0;
      exec_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      w_addr_q <= '0;
      a_addr_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      kij_q    <= kij_d;
      l0_wr_q  <= l0_wr_d;
      l0_rd_q  <= l0_rd_d;
      load_q   <= load_d;
      exec_q   <= exec_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      w_addr_q <= w_addr_d;
      a_addr_q <= a_addr_d;
    end
  end

  assign l0_wr   = l0_wr_q;
  assign l0_rd   = l0_rd_q;
  assign load    = load_q;
  assign execute = exec_q;
  assign w_addr  = w_addr_q;
  assign a_addr  = a_addr_q;
  assign kij_idx = kij_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule
